// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - tick-driven countdown timer with sticky irq, one-shot or auto-reload
// Optional tick prescaler enabled by defining TICK_TIMER_PRESCALE_EN.
module tick_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             tick,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             irq,
  input  logic             irq_ack,
  output logic             missed
);

  typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload;
  logic             periodic_q;
  logic             load_fire;
  logic [WIDTH-1:0] count_eff;
  logic             step;
  logic             dec_event;
  logic             expire;

  assign busy       = (state == RUNNING);
  assign load_ready = !busy;
  assign load_fire  = load_valid && load_ready;
  // start must see a count loaded in the same cycle
  assign count_eff  = load_fire ? load_value : count;
  assign dec_event  = busy && tick && !stop && step && (count != '0);
  assign expire     = dec_event && (count == WIDTH'(1));

`ifdef TICK_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          presc_wrap;

  assign presc_wrap = (presc == PW'(PRESCALE - 1));
  assign step       = presc_wrap;

  always_ff @(posedge clk) begin
    if (!res) begin
      presc <= '0;
    end else if (load_fire || start || stop) begin
      presc <= '0;
    end else if (busy && tick) begin
      presc <= presc_wrap ? '0 : presc + PW'(1);
    end
  end
`else
  assign step = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, EXPIRED: begin
        if (start && !stop && (count_eff != '0)) state_nxt = RUNNING;
      end
      RUNNING: begin
        if (stop)                        state_nxt = IDLE;
        else if (expire && !periodic_q)  state_nxt = EXPIRED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      count      <= '0;
      reload     <= '0;
      periodic_q <= 1'b0;
    end else if (load_fire) begin
      count      <= load_value;
      reload     <= load_value;
      periodic_q <= periodic;
    end else if (expire) begin
      count <= periodic_q ? reload : '0;
    end else if (dec_event) begin
      count <= count - WIDTH'(1);
    end
  end

  // an expiry in the same cycle as an ack wins; missed is left alone then
  always_ff @(posedge clk) begin
    if (!res) begin
      irq    <= 1'b0;
      missed <= 1'b0;
    end else if (expire) begin
      irq <= 1'b1;
      if (irq) missed <= 1'b1;
    end else if (irq_ack) begin
      irq    <= 1'b0;
      missed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - directed self-checking bench for tick_timer
module tb_tick_timer;

`ifdef TICK_TIMER_PRESCALE_EN
  localparam int TPS = 4;
`else
  localparam int TPS = 1;
`endif

  logic        clk;
  logic        res;
  logic        tick;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        periodic;
  logic        start;
  logic        stop;
  logic        busy;
  logic [15:0] count;
  logic        irq;
  logic        irq_ack;
  logic        missed;

  int checks = 0;
  int errors = 0;

  tick_timer #(.WIDTH(16), .PRESCALE(4)) dut (
    .clk(clk), .res(res), .tick(tick),
    .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
    .periodic(periodic), .start(start), .stop(stop), .busy(busy),
    .count(count), .irq(irq), .irq_ack(irq_ack), .missed(missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one logical tick: TPS single-cycle tick pulses, ack optionally on the last
  task automatic do_tick(input logic ack);
    for (int k = 0; k < TPS; k++) begin
      tick    = 1'b1;
      irq_ack = ack && (k == TPS - 1);
      cyc();
    end
    tick    = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic p);
    load_valid = 1'b1; load_value = v; periodic = p;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  initial begin
    res = 1'b0; tick = 1'b1; load_valid = 1'b0; load_value = '0; periodic = 1'b0;
    start = 1'b0; stop = 1'b0; irq_ack = 1'b0;

    // 1 reset with tick high
    cyc(); cyc();
    check("rst_count", count, 0);
    check("rst_irq", irq, 0);
    check("rst_missed", missed, 0);
    check("rst_busy", busy, 0);
    check("rst_load_ready", load_ready, 1);
    res = 1'b1; tick = 1'b0;
    cyc();

    // 2 one-shot 5
    do_load(16'd5, 1'b0);
    check("os_loaded", count, 5);
    pulse_start();
    check("os_busy", busy, 1);
    check("os_ready_low", load_ready, 0);
    for (int i = 1; i <= 5; i++) begin
      do_tick(1'b0);
      check("os_count", count, 5 - i);
      if (i < 5) check("os_irq_early", irq, 0);
      cyc(); cyc();
    end
    check("os_irq", irq, 1);
    check("os_busy_done", busy, 0);
    check("os_ready", load_ready, 1);
    do_tick(1'b0); do_tick(1'b0);
    check("os_hold_zero", count, 0);
    ack();
    check("os_ack", irq, 0);

    // 3 periodic 3
    do_load(16'd3, 1'b1);
    pulse_start();
    do_tick(1'b0); check("per_c1", count, 2);
    load_valid = 1'b1; load_value = 16'd9; cyc(); load_valid = 1'b0;
    check("per_load_blocked", count, 2);
    do_tick(1'b0); check("per_c2", count, 1);
    do_tick(1'b0);
    check("per_irq1", irq, 1);
    check("per_reload", count, 3);
    ack();
    check("per_ack", irq, 0);
    do_tick(1'b0); do_tick(1'b0);
    check("per_no_irq", irq, 0);
    do_tick(1'b0);
    check("per_irq2", irq, 1);
    do_tick(1'b0);
    check("per_c7", count, 2);
    check("per_busy", busy, 1);
    stop = 1'b1; irq_ack = 1'b1; cyc(); stop = 1'b0; irq_ack = 1'b0;
    check("per_stopped", busy, 0);

    // 4 stop beats tick
    do_load(16'd4, 1'b0);
    pulse_start();
    do_tick(1'b0); do_tick(1'b0);
    check("stp_pre", count, 2);
    stop = 1'b1; tick = 1'b1; cyc(); stop = 1'b0; tick = 1'b0;
    check("stp_count", count, 2);
    check("stp_busy", busy, 0);
    pulse_start();
    do_tick(1'b0); do_tick(1'b0);
    check("stp_irq", irq, 1);
    check("stp_zero", count, 0);
    ack();
    pulse_start();
    check("stp_start_zero", busy, 0);
    load_valid = 1'b1; load_value = 16'd2; periodic = 1'b0; start = 1'b1;
    cyc();
    load_valid = 1'b0; start = 1'b0;
    check("ld_start_busy", busy, 1);
    check("ld_start_count", count, 2);
    stop = 1'b1; cyc(); stop = 1'b0;

    // 5 overrun
    do_load(16'd1, 1'b1);
    pulse_start();
    do_tick(1'b0);
    check("ovr_irq1", irq, 1);
    check("ovr_missed0", missed, 0);
    check("ovr_count", count, 1);
    do_tick(1'b0);
    check("ovr_missed1", missed, 1);
    do_tick(1'b1);
    check("ovr_ack_irq", irq, 1);
    check("ovr_ack_missed", missed, 1);
    ack();
    check("ovr_clr_irq", irq, 0);
    check("ovr_clr_missed", missed, 0);
    stop = 1'b1; cyc(); stop = 1'b0;

    // 6 raw ticks against the prescaler
    do_load(16'd2, 1'b0);
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
`ifdef TICK_TIMER_PRESCALE_EN
      if (i == 4) check("pre_c4", count, 1);
      if (i == 7) check("pre_irq7", irq, 0);
`else
      if (i == 1) check("pre_c1", count, 1);
      if (i == 2) check("pre_irq2", irq, 1);
`endif
    end
    check("pre_irq8", irq, 1);
    check("pre_c8", count, 0);
    ack();

    // reset mid-run aborts without irq
    do_load(16'd3, 1'b0);
    pulse_start();
    res = 1'b0; tick = 1'b1; cyc(); res = 1'b1; tick = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
